// File: rtl/cdf_pkg.sv
// Shared definitions for the connected-domain filter row-scan logic.
// Holds the scan state encoding, scan direction constants, the pixel-word
// width and the helper that sizes a bit-position field for a row length width.
package cdf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L_ADDR,
    ST_L_WAIT,
    ST_L_DET,
    ST_R_ADDR,
    ST_R_WAIT,
    ST_R_DET,
    ST_DONE
  } scan_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned IDX_W     = $clog2(WORD_BITS);

  // Position = word_offset * WORD_BITS + bit_index.
  function automatic int unsigned pos_width(input int unsigned len_w);
    return len_w + IDX_W;
  endfunction

endpackage

// File: rtl/row_bound_scan_ctrl_if.sv
// BRAM address / bound-detector handshake between the row scan sequencer
// (master) and the shared bound detector plus its BRAM read port (slave).
//   o_bram_addr             : word address of the row word under test
//   o_det_trig              : detector trigger, held until i_det_done
//   o_det_left_or_right     : 0 = left search, 1 = right search
//   i_det_bound_index       : bit index reported by the detector
//   i_det_is_bound_detected : detector found a bound in this word
//   i_det_done              : detector completion pulse
interface row_bound_scan_ctrl_if
  import cdf_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
);

  logic [ADDR_W-1:0] o_bram_addr;
  logic              o_det_trig;
  logic              o_det_left_or_right;
  logic [IDX_W-1:0]  i_det_bound_index;
  logic              i_det_is_bound_detected;
  logic              i_det_done;

  modport master (
    output o_bram_addr, o_det_trig, o_det_left_or_right,
    input  i_det_bound_index, i_det_is_bound_detected, i_det_done
  );

  modport slave (
    input  o_bram_addr, o_det_trig, o_det_left_or_right,
    output i_det_bound_index, i_det_is_bound_detected, i_det_done
  );

endinterface

// File: rtl/row_bound_scan_ctrl.sv
// Row bound scan sequencer: walks a row forward to find its leftmost
// foreground pixel, then backward from the row end to find the rightmost,
// driving BRAM addresses and the shared bound detector.
// Ports:
//   i_clk, i_rst (sync, active-high)
//   i_start, i_row_base, i_row_words : row request from the scheduler
//   o_busy, o_done, o_found, o_left_pos, o_right_pos, o_err : status/result
//   det_if (master) : BRAM address + detector handshake
// Optional build macro ROW_SCAN_TIMEOUT_EN adds a detector watchdog that
// aborts a scan with o_err after TIMEOUT_CYC cycles of o_det_trig.
module row_bound_scan_ctrl
  import cdf_pkg::*;
#(
  parameter int unsigned  ADDR_W      = 13,
  parameter int unsigned  LEN_W       = 8,
  parameter int unsigned  RD_LAT      = 1,
`ifdef ROW_SCAN_TIMEOUT_EN
  parameter int unsigned  TIMEOUT_CYC = 64,
`endif
  localparam int unsigned POS_W       = pos_width(LEN_W)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [ADDR_W-1:0]    i_row_base,
  input  logic [LEN_W-1:0]     i_row_words,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_found,
  output logic [POS_W-1:0]     o_left_pos,
  output logic [POS_W-1:0]     o_right_pos,
  output logic                 o_err,
  row_bound_scan_ctrl_if.master det_if
);

  localparam int unsigned WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic [LEN_W-1:0]  off_q, off_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [POS_W-1:0]  left_pos_q, left_pos_d;
  logic [POS_W-1:0]  right_pos_q, right_pos_d;
  logic              left_hit_q, left_hit_d;
  logic              found_q, found_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              trig_q, trig_d;
  logic              dir_q, dir_d;

  logic [LEN_W-1:0]  last_off_c;
  logic [LEN_W-1:0]  left_word_c;
  logic              timeout_c;

`ifdef ROW_SCAN_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC);
  logic [TCNT_W-1:0] tcnt_q;

  // Cycles spent in the current detect state; restarts on every new word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tcnt_q <= '0;
    end else if (state_q inside {ST_L_DET, ST_R_DET}) begin
      tcnt_q <= tcnt_q + TCNT_W'(1);
    end else begin
      tcnt_q <= '0;
    end
  end

  // o_done trails the DONE state by a cycle, so abort one cycle early to
  // land o_done exactly TIMEOUT_CYC cycles after the trigger rose.
  assign timeout_c = (tcnt_q == TCNT_W'(TIMEOUT_CYC - 2));
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    words_d     = words_q;
    off_d       = off_q;
    wcnt_d      = wcnt_q;
    left_pos_d  = left_pos_q;
    right_pos_d = right_pos_q;
    left_hit_d  = left_hit_q;
    found_d     = found_q;
    err_d       = err_q;
    done_d      = 1'b0;
    last_off_c  = words_q - LEN_W'(1);
    left_word_c = left_pos_q[POS_W-1:IDX_W];

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          base_d      = i_row_base;
          words_d     = i_row_words;
          off_d       = '0;
          left_pos_d  = '0;
          right_pos_d = '0;
          left_hit_d  = 1'b0;
          found_d     = 1'b0;
          err_d       = 1'b0;
          state_d     = (i_row_words == '0) ? ST_DONE : ST_L_ADDR;
        end
      end
      ST_L_ADDR: begin
        wcnt_d  = '0;
        state_d = ST_L_WAIT;
      end
      ST_L_WAIT: begin
        if (wcnt_q == WCNT_W'(RD_LAT - 1)) state_d = ST_L_DET;
        else                               wcnt_d  = wcnt_q + WCNT_W'(1);
      end
      ST_L_DET: begin
        if (det_if.i_det_done) begin
          if (det_if.i_det_is_bound_detected) begin
            left_pos_d = {off_q, det_if.i_det_bound_index};
            left_hit_d = 1'b1;
            off_d      = last_off_c;
            state_d    = ST_R_ADDR;
          end else if (off_q < last_off_c) begin
            off_d   = off_q + LEN_W'(1);
            state_d = ST_L_ADDR;
          end else begin
            state_d = ST_DONE;
          end
        end else if (timeout_c) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_R_ADDR: begin
        wcnt_d  = '0;
        state_d = ST_R_WAIT;
      end
      ST_R_WAIT: begin
        if (wcnt_q == WCNT_W'(RD_LAT - 1)) state_d = ST_R_DET;
        else                               wcnt_d  = wcnt_q + WCNT_W'(1);
      end
      ST_R_DET: begin
        if (det_if.i_det_done) begin
          if (det_if.i_det_is_bound_detected) begin
            right_pos_d = {off_q, det_if.i_det_bound_index};
            state_d     = ST_DONE;
          end else if (off_q > left_word_c) begin
            off_d   = off_q - LEN_W'(1);
            state_d = ST_R_ADDR;
          end else begin
            // The left word always holds a pixel; never expected with a sane detector.
            right_pos_d = left_pos_q;
            state_d     = ST_DONE;
          end
        end else if (timeout_c) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        found_d = left_hit_q & ~err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    trig_d = (state_d inside {ST_L_DET, ST_R_DET});
    dir_d  = (state_d inside {ST_R_ADDR, ST_R_WAIT, ST_R_DET}) ? DIR_RIGHT : DIR_LEFT;
    addr_d = addr_q;
    if (state_d inside {ST_L_ADDR, ST_R_ADDR}) begin
      addr_d = base_d + ADDR_W'(off_d);
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      words_q     <= '0;
      off_q       <= '0;
      wcnt_q      <= '0;
      left_pos_q  <= '0;
      right_pos_q <= '0;
      left_hit_q  <= 1'b0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      trig_q      <= 1'b0;
      dir_q       <= DIR_LEFT;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      words_q     <= words_d;
      off_q       <= off_d;
      wcnt_q      <= wcnt_d;
      left_pos_q  <= left_pos_d;
      right_pos_q <= right_pos_d;
      left_hit_q  <= left_hit_d;
      found_q     <= found_d;
      err_q       <= err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      trig_q      <= trig_d;
      dir_q       <= dir_d;
    end
  end

  assign o_busy                     = busy_q;
  assign o_done                     = done_q;
  assign o_found                    = found_q;
  assign o_left_pos                 = left_pos_q;
  assign o_right_pos                = right_pos_q;
  assign o_err                      = err_q;
  assign det_if.o_bram_addr         = addr_q;
  assign det_if.o_det_trig          = trig_q;
  assign det_if.o_det_left_or_right = dir_q;

endmodule

// File: tb/tb_row_bound_scan_ctrl.sv
// Bench for row_bound_scan_ctrl: a behavioural detector backed by a pixel
// memory answers triggers after random delays; each row's expected bounds,
// address/direction trace and latency come from a whole-row pixel model.
module tb_row_bound_scan_ctrl;
  import cdf_pkg::*;

  localparam int unsigned ADDR_W      = 13;
  localparam int unsigned LEN_W       = 8;
  localparam int unsigned RD_LAT      = 1;
  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int unsigned POS_W       = LEN_W + 5;
  localparam int unsigned MEM_N       = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [ADDR_W-1:0] i_row_base;
  logic [LEN_W-1:0]  i_row_words;
  logic              o_busy, o_done, o_found, o_err;
  logic [POS_W-1:0]  o_left_pos, o_right_pos;

  row_bound_scan_ctrl_if #(.ADDR_W(ADDR_W)) det_if ();

  row_bound_scan_ctrl #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (i_start),
    .i_row_base  (i_row_base),
    .i_row_words (i_row_words),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_found     (o_found),
    .o_left_pos  (o_left_pos),
    .o_right_pos (o_right_pos),
    .o_err       (o_err),
    .det_if      (det_if)
  );

  always #5 clk = ~clk;

  logic [31:0]       mem [MEM_N];
  int                checks = 0;
  int                errors = 0;
  bit                rsp_hold = 1'b0;
  bit                rsp_active;
  int                rsp_cnt, rsp_delay;
  int                d_sum;
  logic [31:0]       rsp_w;
  logic [ADDR_W-1:0] obs_addr [$];
  logic              obs_dir  [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] lo_bit(input logic [31:0] w);
    for (int i = 0; i < 32; i++) if (w[i]) return 5'(i);
    return 5'd0;
  endfunction

  function automatic logic [4:0] hi_bit(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) if (w[i]) return 5'(i);
    return 5'd0;
  endfunction

  // Behavioural detector: answers a held trigger after 1..4 cycles and
  // throws stray done pulses while idle, which the sequencer must ignore.
  initial begin
    det_if.i_det_done              = 1'b0;
    det_if.i_det_is_bound_detected = 1'b0;
    det_if.i_det_bound_index       = '0;
    rsp_active                     = 1'b0;
    forever begin
      @(negedge clk);
      det_if.i_det_done = 1'b0;
      if (rsp_hold || rst) begin
        rsp_active = 1'b0;
      end else if (det_if.o_det_trig) begin
        if (!rsp_active) begin
          rsp_active = 1'b1;
          rsp_delay  = int'($urandom_range(1, 4));
          rsp_cnt    = rsp_delay;
          obs_addr.push_back(det_if.o_bram_addr);
          obs_dir.push_back(det_if.o_det_left_or_right);
        end
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rsp_w = mem[det_if.o_bram_addr];
          det_if.i_det_is_bound_detected = (rsp_w != 32'd0);
          det_if.i_det_bound_index = det_if.o_det_left_or_right ? hi_bit(rsp_w) : lo_bit(rsp_w);
          det_if.i_det_done = 1'b1;
          rsp_active = 1'b0;
          d_sum += rsp_delay;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        det_if.i_det_done              = 1'b1;
        det_if.i_det_is_bound_detected = 1'b1;
        det_if.i_det_bound_index       = 5'($urandom);
      end
    end
  end

  // Runs one row and compares it with the pixel-level expectation.
  task automatic run_row(input logic [ADDR_W-1:0] base, input int words, input string tag);
    bit                exp_found;
    int                exp_left, exp_right, n_left, n, exp_lat;
    bit                seen;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] exp_addr [$];
    logic              exp_dir  [$];
    exp_found = 1'b0;
    exp_left  = 0;
    exp_right = 0;
    for (int p = 0; p < words * 32; p++) begin
      a = ADDR_W'(int'(base) + p / 32);
      if (mem[a][p % 32]) begin
        if (!exp_found) exp_left = p;
        exp_found = 1'b1;
        exp_right = p;
      end
    end
    n_left = exp_found ? exp_left / 32 + 1 : words;
    for (int k = 0; k < n_left; k++) begin
      exp_addr.push_back(ADDR_W'(int'(base) + k));
      exp_dir.push_back(DIR_LEFT);
    end
    if (exp_found) begin
      for (int k = words - 1; k >= exp_right / 32; k--) begin
        exp_addr.push_back(ADDR_W'(int'(base) + k));
        exp_dir.push_back(DIR_RIGHT);
      end
    end
    obs_addr.delete();
    obs_dir.delete();
    d_sum = 0;

    @(negedge clk);
    i_start     = 1'b1;
    i_row_base  = base;
    i_row_words = LEN_W'(words);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 4000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        // A second request while busy must be ignored.
        i_start     = 1'($urandom_range(0, 1));
        i_row_base  = ADDR_W'($urandom);
        i_row_words = LEN_W'($urandom);
      end else begin
        i_start = 1'b0;
      end
      if (o_done) seen = 1'b1;
    end
    i_start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      exp_lat = 2 + exp_addr.size() * (1 + RD_LAT) + d_sum;
      check({tag, "_latency"}, 64'(n), 64'(exp_lat));
      check({tag, "_busy_at_done"}, 64'(o_busy), 64'd0);
      check({tag, "_found"}, 64'(o_found), 64'(exp_found));
      check({tag, "_err"}, 64'(o_err), 64'd0);
      if (exp_found) begin
        check({tag, "_left"}, 64'(o_left_pos), 64'(exp_left));
        check({tag, "_right"}, 64'(o_right_pos), 64'(exp_right));
      end
      check({tag, "_n_trig"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
      if (obs_addr.size() == exp_addr.size()) begin
        for (int k = 0; k < exp_addr.size(); k++) begin
          check({tag, "_addr"}, 64'(obs_addr[k]), 64'(exp_addr[k]));
          check({tag, "_dir"}, 64'(obs_dir[k]), 64'(exp_dir[k]));
        end
      end
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(o_done), 64'd0);
      check({tag, "_found_hold"}, 64'(o_found), 64'(exp_found));
    end
  endtask

  initial begin
    int n;
    int rd;
    bit seen;
    logic [ADDR_W-1:0] rb;
    int rw;

    rst         = 1'b1;
    i_start     = 1'b0;
    i_row_base  = '0;
    i_row_words = '0;
    for (int i = 0; i < MEM_N; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_found", 64'(o_found), 64'd0);
    check("rst_left", 64'(o_left_pos), 64'd0);
    check("rst_right", 64'(o_right_pos), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_addr", 64'(det_if.o_bram_addr), 64'd0);
    check("rst_trig", 64'(det_if.o_det_trig), 64'd0);
    check("rst_dir", 64'(det_if.o_det_left_or_right), 64'd0);
    rst = 1'b0;

    // Bounds in different words of a 4-word row.
    mem[13'h100] = 32'h0000_0000;
    mem[13'h101] = 32'h0000_0F80;
    mem[13'h102] = 32'h0012_3400;
    mem[13'h103] = 32'h0000_0005;
    run_row(13'h100, 4, "multi");
    check("multi_left_39", 64'(o_left_pos), 64'd39);
    check("multi_right_98", 64'(o_right_pos), 64'd98);
    check("multi_found_1", 64'(o_found), 64'd1);
    check("multi_trace_len", 64'(obs_addr.size()), 64'd3);
    if (obs_addr.size() == 3) begin
      check("multi_addr0", 64'(obs_addr[0]), 64'h100);
      check("multi_addr1", 64'(obs_addr[1]), 64'h101);
      check("multi_addr2", 64'(obs_addr[2]), 64'h103);
    end

    // Single-word row with pixels at both ends.
    mem[13'h055] = 32'h8000_0001;
    run_row(13'h055, 1, "single");
    check("single_left_0", 64'(o_left_pos), 64'd0);
    check("single_right_31", 64'(o_right_pos), 64'd31);

    // Row with no foreground pixels.
    for (int k = 0; k < 3; k++) mem[13'h200 + k] = 32'd0;
    run_row(13'h200, 3, "empty");
    check("empty_found_0", 64'(o_found), 64'd0);
    rd = 0;
    foreach (obs_dir[k]) if (obs_dir[k] == DIR_RIGHT) rd++;
    check("empty_no_right_trig", 64'(rd), 64'd0);

    // Zero-length row.
    run_row(13'h300, 0, "zero");
    check("zero_no_trig", 64'(obs_addr.size()), 64'd0);

    // Row wrapping past the top of the address space.
    mem[13'h1FFE] = 32'd0;
    mem[13'h1FFF] = 32'h0001_0000;
    mem[13'h0000] = 32'h0000_0100;
    run_row(13'h1FFE, 3, "wrap");
    mem[13'h0000] = 32'd0;

    // Reset while the left detect is pending.
    for (int k = 0; k < 3; k++) mem[13'h400 + k] = 32'h0000_0010 << k;
    rsp_hold = 1'b1;
    @(negedge clk);
    i_start     = 1'b1;
    i_row_base  = 13'h400;
    i_row_words = LEN_W'(3);
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (!det_if.o_det_trig && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_trig_seen", 64'(det_if.o_det_trig), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 64'(o_busy), 64'd0);
    check("rst_mid_trig", 64'(det_if.o_det_trig), 64'd0);
    check("rst_mid_done", 64'(o_done), 64'd0);
    rst      = 1'b0;
    rsp_hold = 1'b0;
    @(negedge clk);
    check("rst_mid_done_after", 64'(o_done), 64'd0);
    run_row(13'h400, 3, "post_rst");

`ifdef ROW_SCAN_TIMEOUT_EN
    // Detector that never answers.
    rsp_hold = 1'b1;
    @(negedge clk);
    i_start     = 1'b1;
    i_row_base  = 13'h500;
    i_row_words = LEN_W'(2);
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (!det_if.o_det_trig && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("to_trig_seen", 64'(det_if.o_det_trig), 64'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        i_start     = 1'b1;
        i_row_base  = 13'h600;
        i_row_words = LEN_W'(0);
      end else begin
        i_start = 1'b0;
      end
      if (o_done) seen = 1'b1;
    end
    i_start = 1'b0;
    check("to_done_seen", 64'(seen), 64'd1);
    check("to_latency", 64'(n), 64'(TIMEOUT_CYC));
    check("to_err", 64'(o_err), 64'd1);
    check("to_found", 64'(o_found), 64'd0);
    rsp_hold = 1'b0;
`endif

    // Random rows.
    for (int r = 0; r < 25; r++) begin
      rb = (r % 6 == 5) ? ADDR_W'(MEM_N - 2) : ADDR_W'($urandom);
      rw = int'($urandom_range(0, 6));
      for (int k = 0; k < rw; k++) begin
        case ($urandom_range(0, 3))
          0, 3:    mem[ADDR_W'(int'(rb) + k)] = 32'd0;
          1:       mem[ADDR_W'(int'(rb) + k)] = 32'd1 << $urandom_range(0, 31);
          default: mem[ADDR_W'(int'(rb) + k)] = $urandom;
        endcase
      end
      run_row(rb, rw, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_bound_scan_ctrl.md
# row_bound_scan_ctrl

Sequencer for the 32-bit bound detector in the connected-domain filter. Given a row's base BRAM address and length in 32-bit words, it drives BRAM addresses and detector triggers to find the row's leftmost and rightmost foreground pixels. The left scan walks forward, then the right scan walks backward from the row end. It sits between the row scheduler and one shared bound-detector instance.

## Interface
- `ADDR_W`, 13: BRAM word address width.
- `LEN_W`, 8: row length field width; the maximum row is 255 words.
- `RD_LAT`, 1: BRAM read latency in cycles, from address to valid `i_bram_data`.
- `TIMEOUT_CYC`, 64: detector watchdog limit. Used only when `ROW_SCAN_TIMEOUT_EN` is defined.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset; synchronous, active-high.
- `i_start` in 1: start pulse; accepted only in IDLE.
- `i_row_base` in ADDR_W: BRAM address of the row's first word; sampled at start.
- `i_row_words` in LEN_W: number of words in the row; sampled at start.
- `o_busy` out 1: high from the cycle after start acceptance until DONE.
- `o_done` out 1: one-cycle completion pulse.
- `o_found` out 1: a bound was found; valid with `o_done` and held until the next start.
- `o_left_pos` out LEN_W+5: left bound position, word_offset*32 + bit_index.
- `o_right_pos` out LEN_W+5: right bound position, same encoding.
- `o_err` out 1: timeout abort flag. Constant 0 when the timeout feature is compiled out.
- `o_bram_addr` out ADDR_W: BRAM read address.
- `o_det_trig` out 1: detector trigger; held high until `i_det_done`.
- `o_det_left_or_right` out 1: detector mode; 0 = left search, 1 = right search.
- `i_det_bound_index` in 5: bit index reported by the detector.
- `i_det_is_bound_detected` in 1: detector found a bound in the current word.
- `i_det_done` in 1: detector completion pulse.

## Operation
States:
- IDLE
- L_ADDR → L_WAIT → L_DET: left scan.
- R_ADDR → R_WAIT → R_DET: right scan.
- DONE

Behaviour:
- **Start.** IDLE accepts `i_start`. It latches base and length and sets offset = 0.
  - If `i_row_words` = 0, go directly to DONE with `o_found` = 0.
  - Otherwise go to L_ADDR.
- **Address and wait.** The x_ADDR state drives `o_bram_addr` = base + offset. The address is held through x_WAIT and x_DET. x_WAIT lasts RD_LAT cycles and ends in x_DET.
- **Detect.** In x_DET, `o_det_trig` is high and `o_det_left_or_right` reflects the current scan. The state waits for `i_det_done`.
- **Left scan result.**
  - Detected: latch left_pos = offset*32 + index. Set offset = words−1 and go to R_ADDR.
  - Not detected, offset < words−1: offset+1 and go to L_ADDR.
  - Not detected at the last word: DONE with `o_found` = 0.
- **Right scan result.**
  - Detected: latch right_pos and go to DONE.
  - Not detected, offset > left word: offset−1 and go to R_ADDR.
  - Not detected at the left word: right_pos = left_pos and go to DONE (defensive case).
- **DONE.** Pulse `o_done` for one cycle, set `o_found` = 1 if a left bound was latched, then return to IDLE.
- **Address arithmetic.** base + offset wraps modulo 2^ADDR_W with no error.
- **Unexpected inputs.** `i_start` while busy is ignored. `i_det_done` outside x_DET is ignored.

## Timing
- **Reset values.** All outputs are 0 and the state is IDLE. Reset at any cycle aborts a scan within that cycle with no `o_done`.
- **Per-word cost.** 1 (ADDR) + RD_LAT + detector latency D cycles, with D ≥ 1.
- **Trigger release.** `o_det_trig` deasserts in the cycle after `i_det_done` is sampled.
- **Total latency.** From start to `o_done` is 1 + Σ(per-word costs) + 1 cycles.
- **Empty row.** With `i_row_words` = 0, `o_done` occurs 2 cycles after start.
- **Result hold.** `o_left_pos`, `o_right_pos`, `o_found`, and `o_err` hold until the next accepted start, which clears them.

## Configuration
- **`ROW_SCAN_TIMEOUT_EN` defined:** a counter runs in x_DET. If it reaches TIMEOUT_CYC without `i_det_done`, the block goes to DONE with `o_err` = 1 and `o_found` = 0.
- **`ROW_SCAN_TIMEOUT_EN` undefined:** no counter exists, `o_err` is tied to 0, and the block waits in x_DET indefinitely.

## Structure
- Shared package `cdf_pkg` holds:
  - the state enum;
  - the `DIR_LEFT` = 0 and `DIR_RIGHT` = 1 constants;
  - the `WORD_BITS` = 32 constant;
  - the position-width function.
- Single module, no sub-modules. The detector is instantiated by the parent, not inside this block.

## Test plan
- **Left and right bounds in different words.** Row of 4 words at base 0x100. Word 1 reports left index 7; word 3 reports right index 2. Required: `o_left_pos` = 39, `o_right_pos` = 98, `o_found` = 1. BRAM addresses are 0x100, 0x101, 0x103.
- **Single-word row.** Length 1; detector left index 0 and right index 31. Required: left = 0, right = 31, one `o_done` pulse.
- **Empty-content row.** Length 3 and no detection in any word. Required: `o_found` = 0 after 3 left words, with no right-mode triggers issued.
- **Zero-length row.** Length 0. Required: `o_done` 2 cycles after start, `o_found` = 0, and `o_det_trig` never asserted.
- **Reset mid-scan.** Assert `i_rst` during L_DET. Required: next cycle `o_busy` = 0 and `o_det_trig` = 0, with no `o_done`. A fresh start then completes normally.
- **Timeout (with `ROW_SCAN_TIMEOUT_EN`).** Detector never signals done, TIMEOUT_CYC = 64. Required: `o_done` with `o_err` = 1 exactly 64 cycles after `o_det_trig` rises. A start issued while busy is ignored.
